// File: rtl/cla_result_bcd.sv
// cla_result_bcd: sequential double-dabble converter of the CLA result register to packed BCD.
// Optional seven-segment output enabled by macro CLA_RESULT_BCD_SEVEN_SEG_EN.
`default_nettype none

module cla_result_bcd #(
  parameter int IN_W   = 5,
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [IN_W-1:0]     q_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
`ifdef CLA_RESULT_BCD_SEVEN_SEG_EN
  ,
  output logic [7*DIGITS-1:0] seg
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  if (10 ** DIGITS <= 2 ** IN_W - 1) begin : g_param_check
    $error("cla_result_bcd: DIGITS too small for IN_W");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [IN_W-1:0]  shreg;
  logic [BCD_W-1:0] scratch;
  logic [CNT_W-1:0] cnt;

  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] scratch_nxt;
  logic [IN_W-1:0]  shreg_nxt;

  // Add-3 correction precedes the shift so each nibble stays a valid BCD digit after doubling.
  always_comb begin
    adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
    {scratch_nxt, shreg_nxt} = {adj, shreg} << 1;
  end

`ifdef CLA_RESULT_BCD_SEVEN_SEG_EN
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
`ifdef CLA_RESULT_BCD_SEVEN_SEG_EN
      for (int d = 0; d < DIGITS; d++) seg[7*d +: 7] <= 7'b1000000;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shreg   <= q_in;
            scratch <= '0;
            cnt     <= CNT_W'(IN_W);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          shreg   <= shreg_nxt;
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            bcd   <= scratch_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef CLA_RESULT_BCD_SEVEN_SEG_EN
            for (int d = 0; d < DIGITS; d++) seg[7*d +: 7] <= seg7(scratch_nxt[4*d +: 4]);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cla_result_bcd.sv
// Directed self-checking bench for cla_result_bcd (default IN_W=5, DIGITS=2).
`default_nettype none

module tb_cla_result_bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [4:0] q_in = '0;
  logic       busy;
  logic       done;
  logic [7:0] bcd;
`ifdef CLA_RESULT_BCD_SEVEN_SEG_EN
  logic [13:0] seg;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cla_result_bcd #(.IN_W(5), .DIGITS(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .q_in (q_in),
    .busy (busy),
    .done (done),
    .bcd  (bcd)
`ifdef CLA_RESULT_BCD_SEVEN_SEG_EN
    ,
    .seg  (seg)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done; counts busy-high samples on the way. No comparison here.
  task automatic wait_done(output int busy_cycles, output bit seen);
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_cycles++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Issues a one-cycle load; on return the load edge has passed.
  task automatic issue_load(input logic [4:0] v);
    q_in = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, bcd} !== {1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b bcd=%h, expected 0 0 00", busy, done, bcd);
    end
`ifdef CLA_RESULT_BCD_SEVEN_SEG_EN
    n_cmp++;
    if (seg !== 14'b1000000_1000000) begin
      n_fail++;
      $display("FAIL reset_seg: seg=%b, expected 10000001000000", seg);
    end
`endif
  endtask

  task automatic test_max();
    int  bc;
    bit  seen;
    issue_load(5'd31);
    wait_done(bc, seen);
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL max_timeout: no done within bound");
    end
    n_cmp++;
    if (bc !== 5) begin
      n_fail++;
      $display("FAIL max_busy_len: busy cycles=%0d, expected 5", bc);
    end
    n_cmp++;
    if (bcd !== 8'h31) begin
      n_fail++;
      $display("FAIL max_bcd: bcd=%h, expected 31", bcd);
    end
    step();
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL max_done_width: done=%b one cycle after pulse, expected 0", done);
    end
`ifdef CLA_RESULT_BCD_SEVEN_SEG_EN
    n_cmp++;
    if (seg !== {7'b0110000, 7'b1111001}) begin
      n_fail++;
      $display("FAIL seg_31: seg=%b, expected 01100001111001", seg);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [4:0] vals [5] = '{5'd0, 5'd9, 5'd10, 5'd19, 5'd30};
    logic [7:0] exps [5] = '{8'h00, 8'h09, 8'h10, 8'h19, 8'h30};
    int  bc;
    bit  seen;
    int  dones = 0;
    issue_load(vals[0]);
    for (int i = 0; i < 5; i++) begin
      wait_done(bc, seen);
      if (seen) dones++;
      n_cmp++;
      if (bcd !== exps[i]) begin
        n_fail++;
        $display("FAIL b2b_bcd[%0d]: bcd=%h, expected %h", i, bcd, exps[i]);
      end
      // Load on the done cycle itself: zero-gap restart.
      if (i < 4) issue_load(vals[i+1]);
    end
    step();
    n_cmp++;
    if (dones !== 5 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_count: dones=%0d trailing done=%b, expected 5 0", dones, done);
    end
  endtask

  task automatic test_load_while_busy();
    int dones = 0;
    logic [7:0] prev;
    prev = bcd;
    issue_load(5'd12);
    // Now in busy cycle 1; next step lands in busy cycle 2.
    step();
    q_in = 5'd7;
    load = 1'b1;
    step();
    load = 1'b0;
    n_cmp++;
    if (bcd !== prev) begin
      n_fail++;
      $display("FAIL busy_bcd_hold: bcd=%h mid-conversion, expected previous %h", bcd, prev);
    end
    for (int i = 0; i < 15; i++) begin
      if (done) dones++;
      step();
    end
    n_cmp++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL busy_ignore_dones: done pulses=%0d, expected 1", dones);
    end
    n_cmp++;
    if (bcd !== 8'h12) begin
      n_fail++;
      $display("FAIL busy_ignore_bcd: bcd=%h, expected 12", bcd);
    end
  endtask

  task automatic test_abort();
    int  dones = 0;
    int  bc;
    bit  seen;
    issue_load(5'd25);
    step();
    step();
    // Busy cycle 3: assert rst together with load to check priority.
    rst  = 1'b1;
    load = 1'b1;
    step();
    rst  = 1'b0;
    load = 1'b0;
    n_cmp++;
    if ({busy, done, bcd} !== {1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b done=%b bcd=%h, expected 0 0 00", busy, done, bcd);
    end
    for (int i = 0; i < 8; i++) begin
      if (done || busy) dones++;
      step();
    end
    n_cmp++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet: busy/done samples after abort=%0d, expected 0", dones);
    end
    issue_load(5'd25);
    wait_done(bc, seen);
    n_cmp++;
    if (!seen || bcd !== 8'h25) begin
      n_fail++;
      $display("FAIL abort_reload: seen=%b bcd=%h, expected 1 25", seen, bcd);
    end
  endtask

  task automatic test_exhaustive();
    int  bc;
    bit  seen;
    logic [7:0] expv;
    for (int v = 0; v < 32; v++) begin
      expv = {4'(v / 10), 4'(v % 10)};
      issue_load(5'(v));
      wait_done(bc, seen);
      n_cmp++;
      if (!seen || bcd !== expv || bc !== 5) begin
        n_fail++;
        $display("FAIL exh_%0d: seen=%b bcd=%h busy=%0d, expected 1 %h 5", v, seen, bcd, bc, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_back_to_back();
    test_load_while_busy();
    test_abort();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
